// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline registers.
// It drives en/clear for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable.
// It handles load-use hazards, taken-branch flushes, data-memory waits and halt.
// The optional performance counters are enabled with the macro PIPE_HAZARD_PERF_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// INIT     | first cycle after reset release, clocks zeros into every stage
// RUN      | normal flow, hazard priority: halt > mem wait > branch > load-use
// MEM_WAIT | data memory busy, front end frozen, bubbles issued into WB
// HALT     | pipeline frozen, only reset leaves this state

module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             memread_e,
    input  logic             pcsrc_e,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    input  logic             halt,
    output logic             en_f,
    output logic             en_d,
    output logic             clear_d,
    output logic             en_e,
    output logic             clear_e,
    output logic             en_m,
    output logic             clear_m,
    output logic             en_w,
    output logic             clear_w,
    output logic [1:0]       state_o,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_INIT     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [1:0] S_HALT     = 2'd3;

    // MEM_TIMEOUT is at most 255, so an 8-bit wait counter always suffices.
    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       mem_err_nxt;

    logic       load_use;
    logic       mem_stall;

    // Flow controls shared by RUN and the mem_ready exit of MEM_WAIT.
    logic       flow_en_f;
    logic       flow_en_d;
    logic       flow_clear_d;
    logic       flow_en_e;
    logic       flow_clear_e;

    // Hazard detection; x0 is hardwired to zero so it never creates a dependency.
    always_comb begin
        load_use  = memread_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        mem_stall = mem_req_m && !mem_ready;
    end

    // Branch / load-use / normal flow; a taken branch discards the stalled
    // instruction anyway, so it wins over load-use.
    always_comb begin
        flow_en_f    = 1'b1;
        flow_en_d    = 1'b1;
        flow_clear_d = 1'b0;
        flow_en_e    = 1'b1;
        flow_clear_e = 1'b0;
        if (pcsrc_e) begin
            flow_clear_d = 1'b1;
            flow_clear_e = 1'b1;
        end else if (load_use) begin
            flow_en_f    = 1'b0;
            flow_en_d    = 1'b0;
            flow_clear_e = 1'b1;
        end
    end

    // Output decode and next-state logic. Reset forces the "clear all" pattern
    // combinationally so the registers are held cleared while reset is low.
    always_comb begin
        en_f         = 1'b0;
        en_d         = 1'b0;
        clear_d      = 1'b0;
        en_e         = 1'b0;
        clear_e      = 1'b0;
        en_m         = 1'b0;
        clear_m      = 1'b0;
        en_w         = 1'b0;
        clear_w      = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;

        if (!reset) begin
            clear_d = 1'b1;
            clear_e = 1'b1;
            clear_m = 1'b1;
            clear_w = 1'b1;
        end else begin
            case (state)
                S_INIT: begin
                    en_f      = 1'b1;
                    en_d      = 1'b1;
                    clear_d   = 1'b1;
                    en_e      = 1'b1;
                    clear_e   = 1'b1;
                    en_m      = 1'b1;
                    clear_m   = 1'b1;
                    en_w      = 1'b1;
                    clear_w   = 1'b1;
                    state_nxt = S_RUN;
                end

                S_RUN: begin
                    if (halt) begin
                        state_nxt = S_HALT;
                    end else if (mem_stall) begin
                        en_w         = 1'b1;
                        clear_w      = 1'b1;
                        state_nxt    = S_MEM_WAIT;
                        wait_cnt_nxt = 8'd1;
                    end else begin
                        en_f    = flow_en_f;
                        en_d    = flow_en_d;
                        clear_d = flow_clear_d;
                        en_e    = flow_en_e;
                        clear_e = flow_clear_e;
                        en_m    = 1'b1;
                        en_w    = 1'b1;
                    end
                end

                S_MEM_WAIT: begin
                    if (!mem_ready) begin
                        en_w    = 1'b1;
                        clear_w = 1'b1;
                        // The RUN cycle that entered this state already counted
                        // as the first wait cycle.
                        if (wait_cnt + 8'd1 == TIMEOUT_C) begin
                            mem_err_nxt  = 1'b1;
                            state_nxt    = S_HALT;
                            wait_cnt_nxt = 8'd0;
                        end else begin
                            wait_cnt_nxt = wait_cnt + 8'd1;
                        end
                    end else begin
                        // The branch held in the frozen E stage is resolved here.
                        en_f         = flow_en_f;
                        en_d         = flow_en_d;
                        clear_d      = flow_clear_d;
                        en_e         = flow_en_e;
                        clear_e      = flow_clear_e;
                        en_m         = 1'b1;
                        en_w         = 1'b1;
                        state_nxt    = S_RUN;
                        wait_cnt_nxt = 8'd0;
                    end
                end

                default: begin
                    state_nxt = S_HALT;
                end
            endcase
        end
    end

    // State, wait counter and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_INIT;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    assign state_o = state;

`ifdef PIPE_HAZARD_PERF_EN
    // Saturating stall and flush counters; INIT's flush is start-up, not a hazard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (((state == S_RUN) || (state == S_MEM_WAIT)) && !en_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((state != S_INIT) && (clear_d || clear_e) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed control patterns.
// Control vector order: {en_f, en_d, clear_d, en_e, clear_e, en_m, clear_m, en_w, clear_w}.

module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    localparam logic [8:0] C_RST  = 9'b0_01_01_01_01;
    localparam logic [8:0] C_INIT = 9'b1_11_11_11_11;
    localparam logic [8:0] C_RUN  = 9'b1_10_10_10_10;
    localparam logic [8:0] C_MEMW = 9'b0_00_00_00_11;
    localparam logic [8:0] C_BR   = 9'b1_11_11_10_10;
    localparam logic [8:0] C_LU   = 9'b0_00_11_10_10;
    localparam logic [8:0] C_HALT = 9'b0_00_00_00_00;

`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] rs1_d;
    logic [REG_W-1:0] rs2_d;
    logic [REG_W-1:0] rd_e;
    logic             memread_e;
    logic             pcsrc_e;
    logic             mem_req_m;
    logic             mem_ready;
    logic             halt;
    logic             en_f, en_d, clear_d, en_e, clear_e, en_m, clear_m, en_w, clear_w;
    logic [1:0]       state_o;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic [8:0]       ctl;
    logic [4:0]       ens;

    int n_checks = 0;
    int n_fail   = 0;

    assign ctl = {en_f, en_d, clear_d, en_e, clear_e, en_m, clear_m, en_w, clear_w};
    assign ens = {en_f, en_d, en_e, en_m, en_w};

    pipe_hazard_ctrl #(
        .REG_W      (REG_W),
        .MEM_TIMEOUT(16),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rs1_d    (rs1_d),
        .rs2_d    (rs2_d),
        .rd_e     (rd_e),
        .memread_e(memread_e),
        .pcsrc_e  (pcsrc_e),
        .mem_req_m(mem_req_m),
        .mem_ready(mem_ready),
        .halt     (halt),
        .en_f     (en_f),
        .en_d     (en_d),
        .clear_d  (clear_d),
        .en_e     (en_e),
        .clear_e  (clear_e),
        .en_m     (en_m),
        .clear_m  (clear_m),
        .en_w     (en_w),
        .clear_w  (clear_w),
        .state_o  (state_o),
        .mem_err  (mem_err),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move one cycle on, leaving time to drive inputs before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] perf(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic idle_inputs();
        rs1_d     = '0;
        rs2_d     = '0;
        rd_e      = '0;
        memread_e = 1'b0;
        pcsrc_e   = 1'b0;
        mem_req_m = 1'b0;
        mem_ready = 1'b0;
        halt      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ctl", 32'(ctl), 32'(C_RST));
        check_val("rst_state", 32'(state_o), 32'd0);
        check_val("rst_err", 32'(mem_err), 32'd0);
        reset = 1'b1;
        #1;
        check_val("init_ctl", 32'(ctl), 32'(C_INIT));
        check_val("init_state", 32'(state_o), 32'd0);
        tick(); #1;
        check_val("run_ctl", 32'(ctl), 32'(C_RUN));
        check_val("run_state", 32'(state_o), 32'd1);

        // Load-use on rs1, one-cycle bubble.
        tick();
        memread_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd7;
        #1;
        check_val("lu_rs1", 32'(ctl), 32'(C_LU));
        tick();
        memread_e = 1'b0; rd_e = 5'd3; rs1_d = 5'd5;
        #1;
        check_val("lu_after", 32'(ctl), 32'(C_RUN));
        check_val("lu_state", 32'(state_o), 32'd1);

        // Load-use on rs2.
        tick();
        memread_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd3; rs2_d = 5'd7;
        #1;
        check_val("lu_rs2", 32'(ctl), 32'(C_LU));

        // x0 destination never stalls.
        tick();
        memread_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        #1;
        check_val("lu_x0", 32'(ctl), 32'(C_RUN));

        // Matching registers but not a load.
        tick();
        memread_e = 1'b0; rd_e = 5'd9; rs1_d = 5'd9;
        #1;
        check_val("no_load", 32'(ctl), 32'(C_RUN));

        // Branch overrides a concurrent load-use.
        tick();
        memread_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd7; pcsrc_e = 1'b1;
        #1;
        check_val("br_lu", 32'(ctl), 32'(C_BR));

        // Three not-ready cycles then ready.
        tick();
        idle_inputs();
        mem_req_m = 1'b1;
        #1;
        check_val("mw_enter", 32'(ctl), 32'(C_MEMW));
        check_val("mw_enter_st", 32'(state_o), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            check_val("mw_hold", 32'(ctl), 32'(C_MEMW));
            check_val("mw_state", 32'(state_o), 32'd2);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check_val("mw_ready", 32'(ctl), 32'(C_RUN));
        check_val("mw_ready_st", 32'(state_o), 32'd2);
        tick();
        idle_inputs();
        #1;
        check_val("mw_exit_st", 32'(state_o), 32'd1);
        check_val("stall_a", stall_cnt, perf(5));
        check_val("flush_a", flush_cnt, perf(3));

        // Halt ignored during a wait; pending branch honoured on the ready cycle.
        tick();
        mem_req_m = 1'b1;
        #1;
        check_val("mw2_enter", 32'(ctl), 32'(C_MEMW));
        tick();
        halt = 1'b1;
        #1;
        check_val("mw2_halt_ign", 32'(ctl), 32'(C_MEMW));
        tick();
        halt = 1'b0; mem_ready = 1'b1; pcsrc_e = 1'b1;
        #1;
        check_val("mw2_state", 32'(state_o), 32'd2);
        check_val("mw2_branch", 32'(ctl), 32'(C_BR));
        tick();
        idle_inputs();
        #1;
        check_val("mw2_exit_st", 32'(state_o), 32'd1);

        // Memory never ready: timeout after 16 wait cycles.
        tick();
        mem_req_m = 1'b1;
        #1;
        check_val("to_enter", 32'(ctl), 32'(C_MEMW));
        for (int i = 2; i <= 16; i++) begin
            tick(); #1;
            check_val("to_state", 32'(state_o), 32'd2);
            check_val("to_err_low", 32'(mem_err), 32'd0);
        end
        tick(); #1;
        check_val("to_halt_st", 32'(state_o), 32'd3);
        check_val("to_err", 32'(mem_err), 32'd1);
        check_val("to_halt_ctl", 32'(ctl), 32'(C_HALT));
        tick();
        mem_req_m = 1'b0;
        #1;
        check_val("to_held", 32'(ctl), 32'(C_HALT));
        check_val("stall_b", stall_cnt, perf(23));
        check_val("flush_b", flush_cnt, perf(4));

        // Reset from HALT clears everything.
        reset = 1'b0;
        #1;
        check_val("rst2_ctl", 32'(ctl), 32'(C_RST));
        check_val("rst2_state", 32'(state_o), 32'd0);
        check_val("rst2_err", 32'(mem_err), 32'd0);
        check_val("rst2_stall", stall_cnt, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check_val("init2_ctl", 32'(ctl), 32'(C_INIT));
        tick(); #1;
        check_val("run2_ctl", 32'(ctl), 32'(C_RUN));

        // Reset in the middle of a wait aborts it.
        tick();
        mem_req_m = 1'b1;
        #1;
        check_val("mw3_enter", 32'(ctl), 32'(C_MEMW));
        tick(); #1;
        check_val("mw3_state", 32'(state_o), 32'd2);
        reset = 1'b0;
        #1;
        check_val("mw3_rst_st", 32'(state_o), 32'd0);
        check_val("mw3_rst_ctl", 32'(ctl), 32'(C_RST));
        tick();
        reset = 1'b1;
        mem_req_m = 1'b0;
        #1;
        check_val("init3_ctl", 32'(ctl), 32'(C_INIT));
        tick(); #1;
        check_val("run3_ctl", 32'(ctl), 32'(C_RUN));
        check_val("run3_state", 32'(state_o), 32'd1);

        // Halt pulse in RUN.
        tick();
        halt = 1'b1;
        #1;
        check_val("halt_en", 32'(ens), 32'd0);
        tick();
        halt = 1'b0;
        #1;
        check_val("halt_state", 32'(state_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_val("halt_held", 32'(ctl), 32'(C_HALT));
            check_val("halt_held_st", 32'(state_o), 32'd3);
        end
        check_val("stall_c", stall_cnt, perf(1));
        check_val("flush_c", flush_cnt, perf(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
